// File: rtl/rob_commit.sv
// ============================================================================
// Module      : rob_commit
// Description : In-order commit engine built on a circular reorder buffer.
//               Optional macro ROB_BYPASS_EN forwards same-cycle CDB results
//               to the query port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_commit #(
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int REG_NUM_WIDTH  = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      dec_valid_in,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rd_in,
    input  logic                      dec_is_branch_in,
    input  logic                      dec_pred_taken_in,
    input  logic [31:0]               dec_alt_pc_in,
    output logic [ROB_SIZE_WIDTH:0]   new_dependency_out,
    output logic                      full_out,
    input  logic                      cdb_valid_in,
    input  logic [ROB_SIZE_WIDTH:0]   cdb_tag_in,
    input  logic [31:0]               cdb_value_in,
    input  logic                      cdb_taken_in,
    input  logic [ROB_SIZE_WIDTH:0]   query_tag_in,
    output logic                      query_ready_out,
    output logic [31:0]               query_value_out,
    output logic                      rf_valid_out,
    output logic [REG_NUM_WIDTH-1:0]  rf_rd_out,
    output logic [31:0]               rf_value_out,
    output logic [ROB_SIZE_WIDTH:0]   rf_dependency_out,
    output logic                      need_flush_out,
    output logic [31:0]               flush_pc_out
);

    localparam int C_ENTRIES = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] C_FULL_COUNT = (ROB_SIZE_WIDTH+1)'(C_ENTRIES);

    logic [ROB_SIZE_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_SIZE_WIDTH:0]   count_q, count_d;
    logic [C_ENTRIES-1:0]      busy_q, busy_d, ready_q, ready_d;
    logic [C_ENTRIES-1:0]      br_q, br_d, pred_q, pred_d, taken_q, taken_d;
    logic [31:0]               value_q [C_ENTRIES];
    logic [31:0]               value_d [C_ENTRIES];
    logic [31:0]               alt_pc_q [C_ENTRIES];
    logic [31:0]               alt_pc_d [C_ENTRIES];
    logic [REG_NUM_WIDTH-1:0]  rd_q [C_ENTRIES];
    logic [REG_NUM_WIDTH-1:0]  rd_d [C_ENTRIES];

    logic                      rf_valid_q, rf_valid_d, flush_q, flush_d;
    logic [REG_NUM_WIDTH-1:0]  rf_rd_q, rf_rd_d;
    logic [31:0]               rf_value_q, rf_value_d, flush_pc_q, flush_pc_d;
    logic [ROB_SIZE_WIDTH:0]   rf_dep_q, rf_dep_d;

    logic                      w_dispatch, w_complete, w_commit, w_mispredict;
    logic [ROB_SIZE_WIDTH-1:0] w_cdb_idx, w_query_idx;

    assign full_out           = (count_q == C_FULL_COUNT);
    assign new_dependency_out = {1'b0, tail_q};
    assign w_cdb_idx          = cdb_tag_in[ROB_SIZE_WIDTH-1:0];
    assign w_query_idx        = query_tag_in[ROB_SIZE_WIDTH-1:0];
    assign w_dispatch         = dec_valid_in && !full_out;
    assign w_complete         = cdb_valid_in && !cdb_tag_in[ROB_SIZE_WIDTH] && busy_q[w_cdb_idx];
    // Only results registered before this edge may retire.
    assign w_commit           = busy_q[head_q] && ready_q[head_q];
    assign w_mispredict       = w_commit && br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        br_d       = br_q;
        pred_d     = pred_q;
        taken_d    = taken_q;
        value_d    = value_q;
        alt_pc_d   = alt_pc_q;
        rd_d       = rd_q;
        rf_valid_d = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_value_d = rf_value_q;
        rf_dep_d   = rf_dep_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;

        if (w_mispredict) begin
            // Everything younger than the branch is wrong-path work.
            flush_d    = 1'b1;
            flush_pc_d = alt_pc_q[head_q];
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            busy_d     = '0;
            ready_d    = '0;
        end else begin
            if (w_complete) begin
                ready_d[w_cdb_idx] = 1'b1;
                value_d[w_cdb_idx] = cdb_value_in;
                taken_d[w_cdb_idx] = cdb_taken_in;
            end
            if (w_dispatch) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = 1'b0;
                br_d[tail_q]     = dec_is_branch_in;
                pred_d[tail_q]   = dec_pred_taken_in;
                alt_pc_d[tail_q] = dec_alt_pc_in;
                rd_d[tail_q]     = dec_rd_in;
                tail_d           = tail_q + 1'b1;
            end
            if (w_commit) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
                if (!br_q[head_q]) begin
                    rf_valid_d = 1'b1;
                    rf_rd_d    = rd_q[head_q];
                    rf_value_d = value_q[head_q];
                    rf_dep_d   = {1'b0, head_q};
                end
            end
            if (w_dispatch && !w_commit) begin
                count_d = count_q + 1'b1;
            end else if (!w_dispatch && w_commit) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            ready_q    <= '0;
            br_q       <= '0;
            pred_q     <= '0;
            taken_q    <= '0;
            rf_valid_q <= 1'b0;
            rf_rd_q    <= '0;
            rf_value_q <= '0;
            rf_dep_q   <= '1;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else if (rdy_in) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            br_q       <= br_d;
            pred_q     <= pred_d;
            taken_q    <= taken_d;
            rf_valid_q <= rf_valid_d;
            rf_rd_q    <= rf_rd_d;
            rf_value_q <= rf_value_d;
            rf_dep_q   <= rf_dep_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // Payload is qualified by busy/ready, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            value_q  <= value_d;
            alt_pc_q <= alt_pc_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        query_ready_out = 1'b0;
        query_value_out = '0;
        if (!query_tag_in[ROB_SIZE_WIDTH] && busy_q[w_query_idx]) begin
            if (ready_q[w_query_idx]) begin
                query_ready_out = 1'b1;
                query_value_out = value_q[w_query_idx];
            end
`ifdef ROB_BYPASS_EN
            if (cdb_valid_in && (cdb_tag_in == query_tag_in)) begin
                query_ready_out = 1'b1;
                query_value_out = cdb_value_in;
            end
`endif
        end
    end

    assign rf_valid_out      = rf_valid_q;
    assign rf_rd_out         = rf_rd_q;
    assign rf_value_out      = rf_value_q;
    assign rf_dependency_out = rf_dep_q;
    assign need_flush_out    = flush_q;
    assign flush_pc_out      = flush_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_rob_commit.sv
// ============================================================================
// Module      : tb_rob_commit
// Description : Self-checking bench for rob_commit with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_commit;

    logic        clk_in, rst_in, rdy_in;
    logic        dec_valid_in, dec_is_branch_in, dec_pred_taken_in;
    logic [4:0]  dec_rd_in;
    logic [31:0] dec_alt_pc_in;
    logic [3:0]  new_dependency_out;
    logic        full_out;
    logic        cdb_valid_in, cdb_taken_in;
    logic [3:0]  cdb_tag_in;
    logic [31:0] cdb_value_in;
    logic [3:0]  query_tag_in;
    logic        query_ready_out;
    logic [31:0] query_value_out;
    logic        rf_valid_out, need_flush_out;
    logic [4:0]  rf_rd_out;
    logic [31:0] rf_value_out, flush_pc_out;
    logic [3:0]  rf_dependency_out;

    int tests_run = 0;
    int tests_failed = 0;

    rob_commit #(.ROB_SIZE_WIDTH(3), .REG_NUM_WIDTH(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_valid_in(dec_valid_in), .dec_rd_in(dec_rd_in),
        .dec_is_branch_in(dec_is_branch_in), .dec_pred_taken_in(dec_pred_taken_in),
        .dec_alt_pc_in(dec_alt_pc_in), .new_dependency_out(new_dependency_out),
        .full_out(full_out), .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in),
        .cdb_value_in(cdb_value_in), .cdb_taken_in(cdb_taken_in),
        .query_tag_in(query_tag_in), .query_ready_out(query_ready_out),
        .query_value_out(query_value_out), .rf_valid_out(rf_valid_out),
        .rf_rd_out(rf_rd_out), .rf_value_out(rf_value_out),
        .rf_dependency_out(rf_dependency_out), .need_flush_out(need_flush_out),
        .flush_pc_out(flush_pc_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Reference model: program-order queue of in-flight instructions.
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic        br;
        logic        pred;
        logic [31:0] alt;
        logic        rdy;
        logic [31:0] val;
        logic        tkn;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    logic        e_rf_valid, e_flush;
    logic [4:0]  e_rf_rd;
    logic [31:0] e_rf_value, e_flush_pc;
    logic [3:0]  e_rf_dep;

    task automatic model_reset();
        mq.delete();
        m_tail     = 0;
        e_rf_valid = 1'b0;
        e_rf_rd    = '0;
        e_rf_value = '0;
        e_rf_dep   = 4'hF;
        e_flush    = 1'b0;
        e_flush_pc = '0;
    endtask

    task automatic model_edge();
        bit   was_full, flushed;
        ent_t e;
        if (!rdy_in) return;
        was_full   = (mq.size() == 8);
        flushed    = 0;
        e_rf_valid = 1'b0;
        e_flush    = 1'b0;
        if (mq.size() > 0 && mq[0].rdy) begin
            e = mq.pop_front();
            if (!e.br) begin
                e_rf_valid = 1'b1;
                e_rf_rd    = e.rd;
                e_rf_value = e.val;
                e_rf_dep   = e.tag;
            end else if (e.tkn != e.pred) begin
                e_flush    = 1'b1;
                e_flush_pc = e.alt;
                mq.delete();
                m_tail     = 0;
                flushed    = 1;
            end
        end
        if (!flushed) begin
            if (cdb_valid_in) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == cdb_tag_in) begin
                        mq[i].rdy = 1'b1;
                        mq[i].val = cdb_value_in;
                        mq[i].tkn = cdb_taken_in;
                    end
                end
            end
            if (dec_valid_in && !was_full) begin
                e.tag  = 4'(m_tail);
                e.rd   = dec_rd_in;
                e.br   = dec_is_branch_in;
                e.pred = dec_pred_taken_in;
                e.alt  = dec_alt_pc_in;
                e.rdy  = 1'b0;
                e.val  = '0;
                e.tkn  = 1'b0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % 8;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1;
        dec_valid_in = 1'b0; dec_rd_in = '0; dec_is_branch_in = 1'b0;
        dec_pred_taken_in = 1'b0; dec_alt_pc_in = '0;
        cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_value_in = '0; cdb_taken_in = 1'b0;
        query_tag_in = '0;
    endtask

    task automatic do_reset();
        idle();
        #2 rst_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic br, input logic pred,
                            input logic [31:0] alt);
        dec_valid_in = 1'b1; dec_rd_in = rd; dec_is_branch_in = br;
        dec_pred_taken_in = pred; dec_alt_pc_in = alt;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        idle();
        model_reset();
        #12 rst_in = 1'b1;
        tick();
        tests_run++;
        if ({rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out, need_flush_out, flush_pc_out}
            !== {1'b0, 5'd0, 32'd0, 4'hF, 1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs got v=%0b rd=%0d val=%h dep=%h fl=%0b pc=%h", rf_valid_out,
                     rf_rd_out, rf_value_out, rf_dependency_out, need_flush_out, flush_pc_out);
        end
        tests_run++;
        if ({full_out, new_dependency_out} !== {1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_tail got full=%0b tag=%0d want full=0 tag=0", full_out, new_dependency_out);
        end
    endtask

    task automatic test_basic_commit();
        do_reset();
        tests_run++;
        if (new_dependency_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL basic_tag0 got %0d want 0", new_dependency_out);
        end
        dispatch(5'd5, 1'b0, 1'b0, 32'd0);
        tick();
        idle();
        tests_run++;
        if (new_dependency_out !== 4'd1) begin
            tests_failed++;
            $display("FAIL basic_tag1 got %0d want 1", new_dependency_out);
        end
        cdb_valid_in = 1'b1; cdb_tag_in = 4'd0; cdb_value_in = 32'h1234;
        tick();
        idle();
        tests_run++;
        if (rf_valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_early_commit got rf_valid=%0b want 0", rf_valid_out);
        end
        tick();
        tests_run++;
        if ({rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out} !== {1'b1, 5'd5, 32'h1234, 4'd0}) begin
            tests_failed++;
            $display("FAIL basic_commit got v=%0b rd=%0d val=%h dep=%0d want 1/5/1234/0",
                     rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out);
        end
        tick();
        tests_run++;
        if ({rf_valid_out, rf_value_out} !== {1'b0, 32'h1234}) begin
            tests_failed++;
            $display("FAIL basic_hold got v=%0b val=%h want 0/1234", rf_valid_out, rf_value_out);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            dispatch(5'(i + 1), 1'b0, 1'b0, 32'd0);
            tick();
        end
        tests_run++;
        if ({full_out, new_dependency_out} !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL full_after8 got full=%0b tag=%0d want 1/0", full_out, new_dependency_out);
        end
        tick();
        idle();
        tests_run++;
        if ({full_out, new_dependency_out} !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL full_drop got full=%0b tag=%0d want 1/0", full_out, new_dependency_out);
        end
        cdb_valid_in = 1'b1; cdb_tag_in = 4'd0; cdb_value_in = 32'hAA;
        tick();
        idle();
        tick();
        tests_run++;
        if ({full_out, rf_valid_out, rf_rd_out, rf_dependency_out} !== {1'b0, 1'b1, 5'd1, 4'd0}) begin
            tests_failed++;
            $display("FAIL full_commit got full=%0b v=%0b rd=%0d dep=%0d want 0/1/1/0",
                     full_out, rf_valid_out, rf_rd_out, rf_dependency_out);
        end
        dispatch(5'd9, 1'b0, 1'b0, 32'd0);
        tick();
        idle();
        tests_run++;
        if ({full_out, new_dependency_out} !== {1'b1, 4'd1}) begin
            tests_failed++;
            $display("FAIL wrap_tag got full=%0b tag=%0d want 1/1", full_out, new_dependency_out);
        end
    endtask

    task automatic test_out_of_order();
        logic [3:0] order [3];
        order[0] = 4'd2; order[1] = 4'd1; order[2] = 4'd0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dispatch(5'(10 + i), 1'b0, 1'b0, 32'd0);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            cdb_valid_in = 1'b1; cdb_tag_in = order[i]; cdb_value_in = 32'h100 + 32'(order[i]);
            tick();
            tests_run++;
            if (rf_valid_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL ooo_premature step=%0d got rf_valid=%0b want 0", i, rf_valid_out);
            end
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out}
                !== {1'b1, 5'(10 + i), 32'h100 + 32'(i), 4'(i)}) begin
                tests_failed++;
                $display("FAIL ooo_commit idx=%0d got v=%0b rd=%0d val=%h dep=%0d", i,
                         rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out);
            end
        end
    endtask

    task automatic test_mispredict_flush();
        do_reset();
        dispatch(5'd0, 1'b1, 1'b1, 32'h100);
        tick();
        dispatch(5'd4, 1'b0, 1'b0, 32'd0);
        cdb_valid_in = 1'b1; cdb_tag_in = 4'd0; cdb_taken_in = 1'b0;
        tick();
        idle();
        dispatch(5'd6, 1'b0, 1'b0, 32'd0);
        tick();
        idle();
        query_tag_in = 4'd2;
        #1;
        tests_run++;
        if ({need_flush_out, flush_pc_out, rf_valid_out, full_out, new_dependency_out}
            !== {1'b1, 32'h100, 1'b0, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL flush_pulse got fl=%0b pc=%h v=%0b full=%0b tag=%0d want 1/100/0/0/0",
                     need_flush_out, flush_pc_out, rf_valid_out, full_out, new_dependency_out);
        end
        tests_run++;
        if ({query_ready_out, query_value_out} !== {1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL flush_discard got rdy=%0b val=%h want 0/0", query_ready_out, query_value_out);
        end
        tick();
        tests_run++;
        if ({need_flush_out, flush_pc_out} !== {1'b0, 32'h100}) begin
            tests_failed++;
            $display("FAIL flush_one_cycle got fl=%0b pc=%h want 0/100", need_flush_out, flush_pc_out);
        end
    endtask

    task automatic test_correct_branch_and_async_reset();
        do_reset();
        dispatch(5'd0, 1'b1, 1'b1, 32'h200);
        tick();
        dispatch(5'd7, 1'b0, 1'b0, 32'd0);
        tick();
        idle();
        cdb_valid_in = 1'b1; cdb_tag_in = 4'd0; cdb_taken_in = 1'b1;
        tick();
        cdb_tag_in = 4'd1; cdb_value_in = 32'hABCD; cdb_taken_in = 1'b0;
        tick();
        idle();
        tests_run++;
        if ({rf_valid_out, need_flush_out} !== 2'b00) begin
            tests_failed++;
            $display("FAIL branch_ok got v=%0b fl=%0b want 0/0", rf_valid_out, need_flush_out);
        end
        dispatch(5'd3, 1'b0, 1'b0, 32'd0);
        tick();
        idle();
        tests_run++;
        if ({rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out} !== {1'b1, 5'd7, 32'hABCD, 4'd1}) begin
            tests_failed++;
            $display("FAIL branch_next got v=%0b rd=%0d val=%h dep=%0d want 1/7/abcd/1",
                     rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out);
        end
        #2 rst_in = 1'b0;
        #1;
        tests_run++;
        if ({rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out, need_flush_out, new_dependency_out}
            !== {1'b0, 5'd0, 32'd0, 4'hF, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL async_reset got v=%0b rd=%0d val=%h dep=%h fl=%0b tag=%0d", rf_valid_out,
                     rf_rd_out, rf_value_out, rf_dependency_out, need_flush_out, new_dependency_out);
        end
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dispatch(5'(i), 1'b0, 1'b0, 32'd0);
            tick();
        end
        idle();
        cdb_valid_in = 1'b1; cdb_tag_in = 4'd3; cdb_value_in = 32'd7; query_tag_in = 4'd3;
        #1;
        tests_run++;
`ifdef ROB_BYPASS_EN
        if ({query_ready_out, query_value_out} !== {1'b1, 32'd7}) begin
            tests_failed++;
            $display("FAIL query_bypass got rdy=%0b val=%h want 1/7", query_ready_out, query_value_out);
        end
`else
        if ({query_ready_out, query_value_out} !== {1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL query_nobypass got rdy=%0b val=%h want 0/0", query_ready_out, query_value_out);
        end
`endif
        tick();
        cdb_valid_in = 1'b0;
        #1;
        tests_run++;
        if ({query_ready_out, query_value_out} !== {1'b1, 32'd7}) begin
            tests_failed++;
            $display("FAIL query_stored got rdy=%0b val=%h want 1/7", query_ready_out, query_value_out);
        end
        query_tag_in = 4'hF;
        #1;
        tests_run++;
        if ({query_ready_out, query_value_out} !== {1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL query_nodep got rdy=%0b val=%h want 0/0", query_ready_out, query_value_out);
        end
    endtask

    task automatic test_random();
        logic        er;
        logic [31:0] ev;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy_in            = ($urandom_range(9) != 0);
            dec_valid_in      = ($urandom_range(9) < 6);
            dec_rd_in         = 5'($urandom);
            dec_is_branch_in  = ($urandom_range(9) == 0);
            dec_pred_taken_in = 1'($urandom);
            dec_alt_pc_in     = $urandom;
            cdb_valid_in      = ($urandom_range(9) < 5);
            cdb_value_in      = $urandom;
            cdb_taken_in      = 1'($urandom);
            if (mq.size() > 0 && $urandom_range(4) != 0)
                cdb_tag_in = mq[$urandom_range(mq.size() - 1)].tag;
            else
                cdb_tag_in = 4'($urandom);
            if (mq.size() > 0 && $urandom_range(3) != 0)
                query_tag_in = mq[$urandom_range(mq.size() - 1)].tag;
            else
                query_tag_in = 4'($urandom);
            #1;
            er = 1'b0;
            ev = '0;
            foreach (mq[i]) begin
                if (mq[i].tag == query_tag_in) begin
                    if (mq[i].rdy) begin er = 1'b1; ev = mq[i].val; end
`ifdef ROB_BYPASS_EN
                    if (cdb_valid_in && cdb_tag_in == query_tag_in) begin er = 1'b1; ev = cdb_value_in; end
`endif
                end
            end
            tests_run++;
            if ({full_out, new_dependency_out, query_ready_out, query_value_out}
                !== {(mq.size() == 8), 4'(m_tail), er, ev}) begin
                tests_failed++;
                $display("FAIL rand_comb cyc=%0d got full=%0b tag=%0d qr=%0b qv=%h want %0b/%0d/%0b/%h",
                         cyc, full_out, new_dependency_out, query_ready_out, query_value_out,
                         (mq.size() == 8), m_tail, er, ev);
            end
            tick();
            tests_run++;
            if ({rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out, need_flush_out, flush_pc_out}
                !== {e_rf_valid, e_rf_rd, e_rf_value, e_rf_dep, e_flush, e_flush_pc}) begin
                tests_failed++;
                $display("FAIL rand_commit cyc=%0d got v=%0b rd=%0d val=%h dep=%0d fl=%0b pc=%h want %0b/%0d/%h/%0d/%0b/%h",
                         cyc, rf_valid_out, rf_rd_out, rf_value_out, rf_dependency_out, need_flush_out,
                         flush_pc_out, e_rf_valid, e_rf_rd, e_rf_value, e_rf_dep, e_flush, e_flush_pc);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_out_of_order();
        test_mispredict_flush();
        test_correct_branch_and_async_reset();
        test_query();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
